// File: rtl/cs42448_pkg.sv
// Shared types and constants for the CS42448 I2C arbiter slice.
package cs42448_pkg;

    localparam int CS_PTR_W  = 7;
    localparam int CS_DATA_W = 8;

    // CS42448 7-bit slave address is 10010xx; the two LSBs come from the AD1/AD0 straps.
    localparam logic [6:0] CS_SADDR_BASE = 7'b1001000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/cs42448_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module cs42448_rr_pick
    import cs42448_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] pos_i;
    logic             found;

    // Walk the request vector starting at rr_ptr; the first hit becomes the one-hot grant.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        pos_i = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_i = IDX_W'(pos);
            if (!found && req[pos_i]) begin
                found      = 1'b1;
                gnt[pos_i] = 1'b1;
                idx        = pos_i;
            end
        end
    end

endmodule

// File: rtl/cs42448_i2c_arbiter.sv
// Round-robin arbiter sharing one CS42448 I2C register controller among N_REQ requesters.
// Optional watchdog: define CS42448_ARB_TIMEOUT_EN to abort stuck transactions after
// TIMEOUT_CYCLES sys_clk cycles with req_err set.
module cs42448_i2c_arbiter
    import cs42448_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_rw,
    input  logic [CS_PTR_W*N_REQ-1:0] req_ptr,
    input  logic [CS_DATA_W*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]          req_gnt,
    output logic [N_REQ-1:0]          req_done,
    output logic                      req_err,
    output logic [CS_DATA_W-1:0]      req_rdata,
    output logic                      busy,
    output logic                      i2c_start,
    output logic                      i2c_rw,
    output logic [CS_PTR_W-1:0]       i2c_ptr,
    output logic [CS_DATA_W-1:0]      i2c_wr_byte,
    input  logic                      i2c_ready,
    input  logic                      i2c_done,
    input  logic                      i2c_init_done,
    input  logic [CS_DATA_W-1:0]      i2c_rd_byte
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cs42448_i2c_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     cmd_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [N_REQ-1:0]     pick_gnt;
    logic [N_REQ-1:0]     done_onehot;
    logic                 cmd_rw;
    logic [CS_PTR_W-1:0]  cmd_ptr;
    logic [CS_DATA_W-1:0] cmd_wdata;
    logic                 grant_ok;
    logic                 tmo_hit;

    cs42448_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    // The grant pulse is combinational so it lands in the very cycle the request fields are
    // captured; it is masked during reset so every output reads zero while reset is held.
    assign grant_ok    = (state == ST_IDLE) && !sys_rst && i2c_init_done && i2c_ready && (|req_valid);
    assign req_gnt     = grant_ok ? pick_gnt : '0;
    assign done_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << cmd_idx;

    assign i2c_rw      = cmd_rw;
    assign i2c_ptr     = cmd_ptr;
    assign i2c_wr_byte = cmd_wdata;

`ifdef CS42448_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Watchdog counter restarts on every grant and runs while a command is outstanding.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt <= '0;
        end else if (grant_ok) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE || state == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign tmo_hit = (state == ST_ISSUE || state == ST_BUSY) &&
                     (tmo_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Transaction FSM: grant, hold the strobe until the controller goes busy, wait for
    // completion or NACK, then return the response and advance the round-robin pointer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            cmd_idx   <= '0;
            cmd_rw    <= 1'b0;
            cmd_ptr   <= '0;
            cmd_wdata <= '0;
            i2c_start <= 1'b0;
            busy      <= 1'b0;
            req_done  <= '0;
            req_err   <= 1'b0;
            req_rdata <= '0;
        end else begin
            req_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        cmd_idx   <= pick_idx;
                        cmd_rw    <= req_rw[pick_idx];
                        cmd_ptr   <= req_ptr[int'(pick_idx)*CS_PTR_W +: CS_PTR_W];
                        cmd_wdata <= req_wdata[int'(pick_idx)*CS_DATA_W +: CS_DATA_W];
                        i2c_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!i2c_ready) begin
                        i2c_start <= 1'b0;
                        state     <= ST_BUSY;
                    end else if (tmo_hit) begin
                        i2c_start <= 1'b0;
                        req_err   <= 1'b1;
                        req_done  <= done_onehot;
                        state     <= ST_RESP;
                    end
                end
                ST_BUSY: begin
                    if (i2c_done) begin
                        if (cmd_rw) begin
                            req_rdata <= i2c_rd_byte;
                        end
                        req_err  <= 1'b0;
                        req_done <= done_onehot;
                        state    <= ST_RESP;
                    end else if (i2c_ready || tmo_hit) begin
                        req_err  <= 1'b1;
                        req_done <= done_onehot;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (cmd_idx == IDX_W'(N_REQ - 1)) ? '0 : cmd_idx + 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cs42448_i2c_arbiter.sv
// Directed self-checking bench for cs42448_i2c_arbiter (4 requesters, TIMEOUT_CYCLES = 100).
// Build with CS42448_ARB_TIMEOUT_EN to exercise the watchdog instead of the indefinite wait.
module tb_cs42448_i2c_arbiter;

    localparam int N = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_rw;
    logic [7*N-1:0] req_ptr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]  req_gnt;
    logic [N-1:0]  req_done;
    logic          req_err;
    logic [7:0]    req_rdata;
    logic          busy;
    logic          i2c_start;
    logic          i2c_rw;
    logic [6:0]    i2c_ptr;
    logic [7:0]    i2c_wr_byte;
    logic          i2c_ready;
    logic          i2c_done;
    logic          i2c_init_done;
    logic [7:0]    i2c_rd_byte;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] obs_gnt, obs_done;
    logic         obs_start, obs_rw, obs_err, obs_busy_gnt, obs_busy_issue, obs_busy_resp, obs_timeout;
    logic [6:0]   obs_ptr;
    logic [7:0]   obs_wb, obs_rdata;

    cs42448_i2c_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .req_valid     (req_valid),
        .req_rw        (req_rw),
        .req_ptr       (req_ptr),
        .req_wdata     (req_wdata),
        .req_gnt       (req_gnt),
        .req_done      (req_done),
        .req_err       (req_err),
        .req_rdata     (req_rdata),
        .busy          (busy),
        .i2c_start     (i2c_start),
        .i2c_rw        (i2c_rw),
        .i2c_ptr       (i2c_ptr),
        .i2c_wr_byte   (i2c_wr_byte),
        .i2c_ready     (i2c_ready),
        .i2c_done      (i2c_done),
        .i2c_init_done (i2c_init_done),
        .i2c_rd_byte   (i2c_rd_byte)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_req(input int k, input logic rw, input logic [6:0] p, input logic [7:0] d);
        req_rw[k]            = rw;
        req_ptr[k*7 +: 7]    = p;
        req_wdata[k*8 +: 8]  = d;
    endtask

    // Plays the controller for one transaction and records what the arbiter showed.
    task automatic drive_txn(input logic nack, input logic [7:0] rd);
        obs_timeout = 1'b1;
        obs_gnt = '0; obs_done = '0; obs_start = 1'b0; obs_rw = 1'b0; obs_err = 1'b0;
        obs_ptr = '0; obs_wb = '0; obs_rdata = '0;
        obs_busy_gnt = 1'b1; obs_busy_issue = 1'b0; obs_busy_resp = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_gnt != '0) begin
                obs_timeout = 1'b0;
                break;
            end
            @(negedge sys_clk);
        end
        if (obs_timeout) return;
        obs_gnt      = req_gnt;
        obs_busy_gnt = busy;
        @(negedge sys_clk);
        obs_start      = i2c_start;
        obs_rw         = i2c_rw;
        obs_ptr        = i2c_ptr;
        obs_wb         = i2c_wr_byte;
        obs_busy_issue = busy;
        i2c_ready = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        if (!nack) begin
            i2c_done    = 1'b1;
            i2c_rd_byte = rd;
        end else begin
            i2c_ready = 1'b1;
        end
        @(negedge sys_clk);
        obs_done      = req_done;
        obs_err       = req_err;
        obs_rdata     = req_rdata;
        obs_busy_resp = busy;
        i2c_done  = 1'b0;
        i2c_ready = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; req_valid = 4'hF; req_rw = '0; req_ptr = '0; req_wdata = '0;
        i2c_ready = 1'b1; i2c_done = 1'b0; i2c_init_done = 1'b1; i2c_rd_byte = 8'h00;
        @(negedge sys_clk);
        @(negedge sys_clk);
        #1;
        checks++; if (req_gnt !== 4'h0)   begin errors++; $display("[TB] FAIL reset_gnt got %h want %h", req_gnt, 4'h0); end
        checks++; if (req_done !== 4'h0)  begin errors++; $display("[TB] FAIL reset_done got %h want %h", req_done, 4'h0); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (i2c_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b want 0", i2c_start); end
        checks++; if (req_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata got %h want 00", req_rdata); end
        checks++; if (req_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err got %b want 0", req_err); end
        req_valid = '0;
        i2c_init_done = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_init_gating();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 7'h10 + 7'(k), 8'hA0 + 8'(k));
        req_valid = 4'hF;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (req_gnt != '0 || busy || i2c_start) seen = 1'b1;
            @(negedge sys_clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL init_gate activity got %b want 0", seen); end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_oh;
        int           exp_k;
        i2c_init_done = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_k  = t % N;
            exp_oh = 4'b0001 << exp_k;
            drive_txn(1'b0, 8'h00);
            checks++; if (obs_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rr_grant_wait t=%0d got timeout want grant", t); end
            checks++; if (obs_gnt !== exp_oh)   begin errors++; $display("[TB] FAIL rr_order t=%0d got %b want %b", t, obs_gnt, exp_oh); end
            checks++; if (obs_ptr !== 7'h10 + 7'(exp_k)) begin errors++; $display("[TB] FAIL rr_ptr t=%0d got %h want %h", t, obs_ptr, 7'h10 + 7'(exp_k)); end
            checks++; if (obs_wb !== 8'hA0 + 8'(exp_k))  begin errors++; $display("[TB] FAIL rr_wbyte t=%0d got %h want %h", t, obs_wb, 8'hA0 + 8'(exp_k)); end
            checks++; if (obs_done !== exp_oh)  begin errors++; $display("[TB] FAIL rr_done t=%0d got %b want %b", t, obs_done, exp_oh); end
            checks++; if ({obs_busy_gnt, obs_busy_issue, obs_busy_resp} !== 3'b011)
                begin errors++; $display("[TB] FAIL rr_busy t=%0d got %b want 011", t, {obs_busy_gnt, obs_busy_issue, obs_busy_resp}); end
        end
        req_valid = '0;
        @(negedge sys_clk);
    endtask

    task automatic test_single_write();
        set_req(0, 1'b0, 7'h06, 8'h5A);
        req_valid = 4'b0001;
        drive_txn(1'b0, 8'hEE);
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("[TB] FAIL wr_gnt got %b want 0001", obs_gnt); end
        checks++; if (obs_start !== 1'b1)  begin errors++; $display("[TB] FAIL wr_start_latency got %b want 1", obs_start); end
        checks++; if (obs_ptr !== 7'h06)   begin errors++; $display("[TB] FAIL wr_ptr got %h want 06", obs_ptr); end
        checks++; if (obs_wb !== 8'h5A)    begin errors++; $display("[TB] FAIL wr_byte got %h want 5a", obs_wb); end
        checks++; if (obs_rw !== 1'b0)     begin errors++; $display("[TB] FAIL wr_rw got %b want 0", obs_rw); end
        checks++; if (obs_done !== 4'b0001) begin errors++; $display("[TB] FAIL wr_done got %b want 0001", obs_done); end
        checks++; if (obs_err !== 1'b0)    begin errors++; $display("[TB] FAIL wr_err got %b want 0", obs_err); end
        checks++; if (obs_rdata !== 8'h00) begin errors++; $display("[TB] FAIL wr_rdata_hold got %h want 00", obs_rdata); end
        req_valid = '0;
        @(negedge sys_clk);
    endtask

    task automatic test_read();
        set_req(2, 1'b1, 7'h01, 8'h00);
        req_valid = 4'b0100;
        drive_txn(1'b0, 8'hC4);
        checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("[TB] FAIL rd_gnt got %b want 0100", obs_gnt); end
        checks++; if (obs_rw !== 1'b1)     begin errors++; $display("[TB] FAIL rd_rw got %b want 1", obs_rw); end
        checks++; if (obs_ptr !== 7'h01)   begin errors++; $display("[TB] FAIL rd_ptr got %h want 01", obs_ptr); end
        checks++; if (obs_done !== 4'b0100) begin errors++; $display("[TB] FAIL rd_done got %b want 0100", obs_done); end
        checks++; if (obs_err !== 1'b0)    begin errors++; $display("[TB] FAIL rd_err got %b want 0", obs_err); end
        checks++; if (obs_rdata !== 8'hC4) begin errors++; $display("[TB] FAIL rd_rdata got %h want c4", obs_rdata); end
        req_valid = '0;
        @(negedge sys_clk);
    endtask

    task automatic test_nack();
        set_req(3, 1'b0, 7'h02, 8'h11);
        set_req(1, 1'b0, 7'h03, 8'h22);
        req_valid = 4'b1010;
        drive_txn(1'b1, 8'h00);
        checks++; if (obs_gnt !== 4'b1000)  begin errors++; $display("[TB] FAIL nack_gnt got %b want 1000", obs_gnt); end
        checks++; if (obs_done !== 4'b1000) begin errors++; $display("[TB] FAIL nack_done got %b want 1000", obs_done); end
        checks++; if (obs_err !== 1'b1)     begin errors++; $display("[TB] FAIL nack_err got %b want 1", obs_err); end
        checks++; if (obs_rdata !== 8'hC4)  begin errors++; $display("[TB] FAIL nack_rdata_hold got %h want c4", obs_rdata); end
        req_valid = 4'b0010;
        drive_txn(1'b0, 8'h77);
        checks++; if (obs_gnt !== 4'b0010)  begin errors++; $display("[TB] FAIL after_nack_gnt got %b want 0010", obs_gnt); end
        checks++; if (obs_ptr !== 7'h03)    begin errors++; $display("[TB] FAIL after_nack_ptr got %h want 03", obs_ptr); end
        checks++; if (obs_err !== 1'b0)     begin errors++; $display("[TB] FAIL after_nack_err got %b want 0", obs_err); end
        req_valid = '0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        logic got_gnt;
        seen_done = 1'b0;
        got_gnt   = 1'b0;
        set_req(0, 1'b1, 7'h05, 8'h00);
        req_valid = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (req_gnt == 4'b0001) begin
                got_gnt = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        checks++; if (got_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_gnt got %b want 1", got_gnt); end
        @(negedge sys_clk);
        i2c_ready = 1'b0;
        @(negedge sys_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_before got %b want 1", busy); end
        sys_rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (req_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_rdata got %h want 00", req_rdata); end
        checks++; if (i2c_ptr !== 7'h00)   begin errors++; $display("[TB] FAIL rst_mid_ptr got %h want 00", i2c_ptr); end
        checks++; if (i2c_start !== 1'b0)  begin errors++; $display("[TB] FAIL rst_mid_start got %b want 0", i2c_start); end
        i2c_done = 1'b1;
        i2c_rd_byte = 8'h99;
        for (int n = 0; n < 2; n++) begin
            @(negedge sys_clk);
            if (req_done != '0) seen_done = 1'b1;
        end
        i2c_done = 1'b0;
        req_valid = '0;
        i2c_ready = 1'b1;
        sys_rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge sys_clk);
            if (req_done != '0 || busy) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_no_done got %b want 0", seen_done); end
    endtask

    task automatic test_timeout();
        int   n;
        logic got_gnt;
        logic stray;
        got_gnt = 1'b0;
        stray   = 1'b0;
        n       = 0;
        set_req(1, 1'b0, 7'h07, 8'h33);
        req_valid = 4'b0010;
        for (int w = 0; w < 10; w++) begin
            #1;
            if (req_gnt == 4'b0010) begin
                got_gnt = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        checks++; if (got_gnt !== 1'b1) begin errors++; $display("[TB] FAIL tmo_gnt got %b want 1", got_gnt); end
        @(negedge sys_clk);
        i2c_ready = 1'b0;
`ifdef CS42448_ARB_TIMEOUT_EN
        for (int w = 0; w < 150; w++) begin
            @(negedge sys_clk);
            n++;
            if (req_done != '0) break;
        end
        checks++; if (n !== 100)            begin errors++; $display("[TB] FAIL tmo_latency got %0d want 100", n); end
        checks++; if (req_done !== 4'b0010) begin errors++; $display("[TB] FAIL tmo_done got %b want 0010", req_done); end
        checks++; if (req_err !== 1'b1)     begin errors++; $display("[TB] FAIL tmo_err got %b want 1", req_err); end
        for (int w = 0; w < 10; w++) begin
            @(negedge sys_clk);
            #1;
            if (req_gnt != '0 || i2c_start) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL tmo_no_regrant got %b want 0", stray); end
        req_valid = '0;
        i2c_ready = 1'b1;
        @(negedge sys_clk);
`else
        for (int w = 0; w < 300; w++) begin
            @(negedge sys_clk);
            n++;
            if (req_done != '0 || !busy) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL hang_waits got %b want 0", stray); end
        i2c_ready = 1'b1;
        @(negedge sys_clk);
        checks++; if (req_done !== 4'b0010) begin errors++; $display("[TB] FAIL hang_release_done got %b want 0010", req_done); end
        checks++; if (req_err !== 1'b1)     begin errors++; $display("[TB] FAIL hang_release_err got %b want 1", req_err); end
        req_valid = '0;
        @(negedge sys_clk);
`endif
    endtask

    // Scenario sequence; each task leaves the bench at a negedge with the arbiter idle.
    initial begin
        test_reset();
        test_init_gating();
        test_contention();
        test_single_write();
        test_read();
        test_nack();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
